csr_file_tmr: RTL and testbench



---
 rtl/csr_file_tmr_pkg.sv | 50 +++++
 rtl/csr_file_tmr_if.sv | 28 ++
 rtl/csr_file_tmr_timer.sv | 63 ++++++
 rtl/csr_file_tmr.sv | 173 +++++++++++++++++
 tb/tb_csr_file_tmr.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_file_tmr_pkg.sv
// rtl/csr_file_tmr_pkg.sv - CSR addresses, field positions and ecodes for the CSR file
package csr_file_tmr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0c;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    localparam int PLV_LO        = 0;
    localparam int PLV_HI        = 1;
    localparam int IE_BIT        = 2;
    localparam int PPLV_LO       = 0;
    localparam int PPLV_HI       = 1;
    localparam int PIE_BIT       = 2;
    localparam int LIE_HI        = 12;
    localparam int IS_HI         = 12;
    localparam int IS_HWI_LO     = 2;
    localparam int IS_TIMER      = 11;
    localparam int IS_IPI        = 12;
    localparam int ECODE_LO      = 16;
    localparam int ESUBCODE_LO   = 22;
    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;
    localparam int TCFG_INITV_LO = 2;
    localparam int TICLR_CLR     = 0;

    localparam logic [8:0] CRMD_RST = 9'h008;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;

    function automatic logic [31:0] mask_write(input logic [31:0] old_val,
                                               input logic [31:0] wmask,
                                               input logic [31:0] wvalue);
        return (wmask & wvalue) | (~wmask & old_val);
    endfunction

endpackage

// File: rtl/csr_file_tmr_if.sv
// rtl/csr_file_tmr_if.sv - CSR access and WB commit bus between pipeline and CSR file
interface csr_file_tmr_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        wb_ertn;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        wb_badv_we;
    logic [31:0] wb_vaddr;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        output wb_ex, wb_ertn, wb_ecode, wb_esubcode, wb_pc, wb_badv_we, wb_vaddr,
        input  csr_rvalue
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        input  wb_ex, wb_ertn, wb_ecode, wb_esubcode, wb_pc, wb_badv_we, wb_vaddr,
        output csr_rvalue
    );
endinterface

// File: rtl/csr_file_tmr_timer.sv
// rtl/csr_file_tmr_timer.sv - TCFG/TVAL countdown timer producing a one-cycle timer_set pulse
module csr_file_tmr_timer
    import csr_file_tmr_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tcfg_we,
    input  logic [31:0] wmask,
    input  logic [31:0] wvalue,
    output logic [31:0] tcfg_rvalue,
    output logic [31:0] tval_rvalue,
    output logic        timer_set
);

    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               done_q, done_d;
    logic [TIMER_W-1:0] tcfg_new;

    assign tcfg_rvalue = 32'(tcfg_q);
    assign tval_rvalue = 32'(tval_q);

    always_comb begin
        tcfg_d    = tcfg_q;
        tval_d    = tval_q;
        done_d    = done_q;
        timer_set = 1'b0;
        tcfg_new  = TIMER_W'(mask_write(32'(tcfg_q), wmask, wvalue));
        if (tcfg_we) begin
            tcfg_d = tcfg_new;
            tval_d = {tcfg_new[TIMER_W-1:TCFG_INITV_LO], 2'b00};
            done_d = 1'b0;
        end else if (tcfg_q[TCFG_EN] && !done_q) begin
            if (tval_q != '0) begin
                tval_d = tval_q - 1'b1;
            end else begin
                timer_set = 1'b1;
                // one-shot parks at all-ones so a stale zero cannot refire
                if (tcfg_q[TCFG_PERIODIC]) begin
                    tval_d = {tcfg_q[TIMER_W-1:TCFG_INITV_LO], 2'b00};
                end else begin
                    tval_d = '1;
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg_q <= '0;
            tval_q <= '0;
            done_q <= 1'b0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/csr_file_tmr.sv
// rtl/csr_file_tmr.sv - control/status register file with timer, sampled interrupts and WB commit
module csr_file_tmr
    import csr_file_tmr_pkg::*;
#(
    parameter int          TIMER_W  = 32,
    parameter int          HWI_NUM  = 8,
    parameter int          SAVE_NUM = 4,
    parameter logic [31:0] TID_RST  = 32'h0
) (
    input  logic               clk,
    input  logic               resetn,
    csr_file_tmr_if.slave      bus,
    input  logic [HWI_NUM-1:0] hw_int_in,
    input  logic               ipi_int_in,
    output logic [31:0]        ex_entry,
    output logic [31:0]        ertn_entry,
    output logic               has_int
);

    logic [8:0]  crmd_q, crmd_d;
    logic [2:0]  prmd_q, prmd_d;
    logic [12:0] ecfg_q, ecfg_d;
    logic [12:0] is_q, is_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [25:0] eentry_q, eentry_d;
    logic [31:0] tid_q, tid_d;
    logic [31:0] save_q [SAVE_NUM];
    logic [31:0] save_d [SAVE_NUM];

    logic [31:0] crmd_rd, prmd_rd, ecfg_rd, estat_rd, eentry_rd, tcfg_rd, tval_rd;
    logic [31:0] rdata;
    logic        tcfg_we, ticlr_clr, timer_set;
    logic        unused_csr_re;

    assign unused_csr_re = bus.csr_re;
    assign crmd_rd   = {23'b0, crmd_q};
    assign prmd_rd   = {29'b0, prmd_q};
    assign ecfg_rd   = {19'b0, ecfg_q};
    assign estat_rd  = {1'b0, esub_q, ecode_q, 3'b0, is_q};
    assign eentry_rd = {eentry_q, 6'b0};

    assign tcfg_we   = bus.csr_we && (bus.csr_num == CSR_TCFG);
    assign ticlr_clr = bus.csr_we && (bus.csr_num == CSR_TICLR)
                       && bus.csr_wmask[TICLR_CLR] && bus.csr_wvalue[TICLR_CLR];

    csr_file_tmr_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .tcfg_we     (tcfg_we),
        .wmask       (bus.csr_wmask),
        .wvalue      (bus.csr_wvalue),
        .tcfg_rvalue (tcfg_rd),
        .tval_rvalue (tval_rd),
        .timer_set   (timer_set)
    );

    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        ecfg_d   = ecfg_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        tid_d    = tid_q;
        save_d   = save_q;

        is_d                        = '0;
        is_d[1:0]                   = is_q[1:0];
        is_d[IS_HWI_LO +: HWI_NUM]  = hw_int_in;
        is_d[IS_IPI]                = ipi_int_in;
        is_d[IS_TIMER]              = timer_set | (is_q[IS_TIMER] & ~ticlr_clr);

        // an exception commit swallows same-cycle software writes to the registers it owns
        if (bus.wb_ex) begin
            crmd_d[PLV_HI:PLV_LO] = 2'b00;
            crmd_d[IE_BIT]        = 1'b0;
            prmd_d                = {crmd_q[IE_BIT], crmd_q[PLV_HI:PLV_LO]};
            era_d                 = bus.wb_pc;
            ecode_d               = bus.wb_ecode;
            esub_d                = bus.wb_esubcode;
            if (bus.wb_badv_we) begin
                badv_d = bus.wb_vaddr;
            end
        end else begin
            if (bus.wb_ertn) begin
                crmd_d[PLV_HI:PLV_LO] = prmd_q[PPLV_HI:PPLV_LO];
                crmd_d[IE_BIT]        = prmd_q[PIE_BIT];
            end else if (bus.csr_we && bus.csr_num == CSR_CRMD) begin
                crmd_d = 9'(mask_write(crmd_rd, bus.csr_wmask, bus.csr_wvalue));
            end
            if (bus.csr_we && bus.csr_num == CSR_PRMD)
                prmd_d = 3'(mask_write(prmd_rd, bus.csr_wmask, bus.csr_wvalue));
            if (bus.csr_we && bus.csr_num == CSR_ERA)
                era_d = mask_write(era_q, bus.csr_wmask, bus.csr_wvalue);
            if (bus.csr_we && bus.csr_num == CSR_BADV)
                badv_d = mask_write(badv_q, bus.csr_wmask, bus.csr_wvalue);
            if (bus.csr_we && bus.csr_num == CSR_ESTAT)
                is_d[1:0] = 2'(mask_write(estat_rd, bus.csr_wmask, bus.csr_wvalue));
        end

        if (bus.csr_we && bus.csr_num == CSR_ECFG)
            ecfg_d = ecfg_q & 13'h0 | 13'(mask_write(ecfg_rd, bus.csr_wmask, bus.csr_wvalue));
        if (bus.csr_we && bus.csr_num == CSR_EENTRY)
            eentry_d = 26'(mask_write(eentry_rd, bus.csr_wmask, bus.csr_wvalue) >> 6);
        if (bus.csr_we && bus.csr_num == CSR_TID)
            tid_d = mask_write(tid_q, bus.csr_wmask, bus.csr_wvalue);
        for (int i = 0; i < SAVE_NUM; i++) begin
            if (bus.csr_we && bus.csr_num == CSR_SAVE0 + 14'(i))
                save_d[i] = mask_write(save_q[i], bus.csr_wmask, bus.csr_wvalue);
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.csr_num)
            CSR_CRMD:   rdata = crmd_rd;
            CSR_PRMD:   rdata = prmd_rd;
            CSR_ECFG:   rdata = ecfg_rd;
            CSR_ESTAT:  rdata = estat_rd;
            CSR_ERA:    rdata = era_q;
            CSR_BADV:   rdata = badv_q;
            CSR_EENTRY: rdata = eentry_rd;
            CSR_TID:    rdata = tid_q;
            CSR_TCFG:   rdata = tcfg_rd;
            CSR_TVAL:   rdata = tval_rd;
            default: begin
                for (int i = 0; i < SAVE_NUM; i++) begin
                    if (bus.csr_num == CSR_SAVE0 + 14'(i))
                        rdata = save_q[i];
                end
            end
        endcase
    end

    assign bus.csr_rvalue = rdata;
    assign ex_entry       = eentry_rd;
    assign ertn_entry     = era_q;
    assign has_int        = crmd_q[IE_BIT] & |(ecfg_q[LIE_HI:0] & is_q[IS_HI:0]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q   <= CRMD_RST;
            prmd_q   <= '0;
            ecfg_q   <= '0;
            is_q     <= '0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            tid_q    <= TID_RST;
            for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            is_q     <= is_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            tid_q    <= tid_d;
            save_q   <= save_d;
        end
    end

endmodule

// File: tb/tb_csr_file_tmr.sv
// tb/tb_csr_file_tmr.sv - randomized and directed self-checking bench for csr_file_tmr
module tb_csr_file_tmr;

    localparam int          TW   = 16;
    localparam int          HWI  = 5;
    localparam int          SN   = 4;
    localparam logic [31:0] TIDR = 32'h1234_5678;
    localparam logic [31:0] TMASK = (32'h1 << TW) - 1;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [HWI-1:0] hw_int = '0;
    logic           ipi = 1'b0;
    logic [31:0]    ex_entry, ertn_entry;
    logic           has_int;

    csr_file_tmr_if bus ();

    csr_file_tmr #(.TIMER_W(TW), .HWI_NUM(HWI), .SAVE_NUM(SN), .TID_RST(TIDR)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .hw_int_in  (hw_int),
        .ipi_int_in (ipi),
        .ex_entry   (ex_entry),
        .ertn_entry (ertn_entry),
        .has_int    (has_int)
    );

    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry, m_tid, m_tcfg, m_tval;
    logic [31:0] m_save [SN];
    bit          m_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_badv = 0;
        m_eentry = 0; m_tid = TIDR; m_tcfg = 0; m_tval = 0; m_done = 0;
        for (int i = 0; i < SN; i++) m_save[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [13:0] a);
        case (a)
            14'h00: return m_crmd;
            14'h01: return m_prmd;
            14'h04: return m_ecfg;
            14'h05: return m_estat;
            14'h06: return m_era;
            14'h07: return m_badv;
            14'h0c: return m_eentry;
            14'h40: return m_tid;
            14'h41: return m_tcfg;
            14'h42: return m_tval;
            default: begin
                if (a >= 14'h30 && a < 14'h30 + SN) return m_save[int'(a - 14'h30)];
                return 32'h0;
            end
        endcase
    endfunction

    function automatic logic [31:0] mw(input logic [31:0] old_val);
        return (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & old_val);
    endfunction

    function automatic bit hit(input logic [13:0] a);
        return bus.csr_we && bus.csr_num == a;
    endfunction

    // architectural next state from the register rules, one clock at a time
    task automatic model_next();
        logic [31:0] n_crmd, n_prmd, sw, codes, hwb;
        bit ex, er, fired, tbit, clr;
        ex = bus.wb_ex; er = bus.wb_ertn; fired = 0;
        clr = hit(14'h44) && bus.csr_wmask[0] && bus.csr_wvalue[0];
        n_crmd = m_crmd; n_prmd = m_prmd;
        if (ex) begin
            n_crmd = m_crmd & ~32'h7;
            n_prmd = m_crmd & 32'h7;
            m_era = bus.wb_pc;
            if (bus.wb_badv_we) m_badv = bus.wb_vaddr;
        end else begin
            if (er) n_crmd = (m_crmd & ~32'h7) | (m_prmd & 32'h7);
            else if (hit(14'h00)) n_crmd = mw(m_crmd) & 32'h1ff;
            if (hit(14'h01)) n_prmd = mw(m_prmd) & 32'h7;
            if (hit(14'h06)) m_era = mw(m_era);
            if (hit(14'h07)) m_badv = mw(m_badv);
        end
        if (hit(14'h04)) m_ecfg = mw(m_ecfg) & 32'h1fff;
        if (hit(14'h0c)) m_eentry = mw(m_eentry) & 32'hffff_ffc0;
        if (hit(14'h40)) m_tid = mw(m_tid);
        for (int i = 0; i < SN; i++) if (hit(14'h30 + 14'(i))) m_save[i] = mw(m_save[i]);
        if (hit(14'h41)) begin
            m_tcfg = mw(m_tcfg) & TMASK;
            m_tval = m_tcfg & ~32'h3;
            m_done = 0;
        end else if (m_tcfg[0] && !m_done) begin
            if (m_tval != 0) m_tval = m_tval - 1;
            else begin
                fired = 1;
                if (m_tcfg[1]) m_tval = m_tcfg & ~32'h3;
                else begin m_tval = TMASK; m_done = 1; end
            end
        end
        sw    = (!ex && hit(14'h05)) ? (mw(m_estat) & 32'h3) : (m_estat & 32'h3);
        codes = ex ? (32'({bus.wb_esubcode, bus.wb_ecode}) << 16) : (m_estat & 32'h7fff_0000);
        hwb   = 32'(hw_int) << 2;
        tbit  = fired ? 1'b1 : (clr ? 1'b0 : m_estat[11]);
        m_estat = codes | sw | hwb | (32'(tbit) << 11) | (32'(ipi) << 12);
        m_crmd = n_crmd; m_prmd = n_prmd;
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        bus.csr_we = 0; bus.wb_ex = 0; bus.wb_ertn = 0; bus.wb_badv_we = 0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] v);
        bus.csr_we = 1; bus.csr_num = a; bus.csr_wmask = 32'hffff_ffff; bus.csr_wvalue = v;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] a, input logic [31:0] exp);
        bus.csr_num = a;
        #1;
        chk(tag, bus.csr_rvalue, exp);
    endtask

    task automatic bit_chk(input string tag, input logic [13:0] a, input int b, input logic exp);
        bus.csr_num = a;
        #1;
        chk(tag, 32'(bus.csr_rvalue[b]), 32'(exp));
    endtask

    task automatic mdl_chk(input logic [13:0] a);
        rd_chk($sformatf("model_rd_%02h", a), a, m_read(a));
    endtask

    logic [13:0] addrs [19] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0c, 14'h30, 14'h31,
                                14'h32, 14'h33, 14'h34, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02, 14'h45, 14'h3f};

    initial begin
        bus.csr_re = 0; bus.csr_num = 0; bus.csr_we = 0; bus.csr_wmask = 0; bus.csr_wvalue = 0;
        bus.wb_ex = 0; bus.wb_ertn = 0; bus.wb_ecode = 0; bus.wb_esubcode = 0; bus.wb_pc = 0;
        bus.wb_badv_we = 0; bus.wb_vaddr = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1;

        rd_chk("rst_crmd", 14'h00, 32'h8);
        rd_chk("rst_estat", 14'h05, 32'h0);
        rd_chk("rst_era", 14'h06, 32'h0);
        rd_chk("rst_tcfg", 14'h41, 32'h0);
        rd_chk("rst_tval", 14'h42, 32'h0);
        rd_chk("rst_tid", 14'h40, TIDR);
        chk("rst_has_int", 32'(has_int), 32'h0);
        chk("rst_ex_entry", ex_entry, 32'h0);
        chk("rst_ertn_entry", ertn_entry, 32'h0);

        wr(14'h00, 32'h0000_000f);
        rd_chk("crmd_wr", 14'h00, 32'hf);
        bus.wb_ex = 1; bus.wb_ecode = 6'h0b; bus.wb_esubcode = 0; bus.wb_pc = 32'h1c00_0100;
        tick();
        rd_chk("ex_prmd", 14'h01, 32'h7);
        rd_chk("ex_crmd", 14'h00, 32'h8);
        rd_chk("ex_era", 14'h06, 32'h1c00_0100);
        bus.csr_num = 14'h05; #1;
        chk("ex_ecode", (bus.csr_rvalue >> 16) & 32'h3f, 32'h0b);
        chk("ertn_entry", ertn_entry, 32'h1c00_0100);
        bus.wb_ertn = 1;
        tick();
        rd_chk("ertn_crmd", 14'h00, 32'hf);

        wr(14'h41, 32'h7);
        rd_chk("tval_t1", 14'h42, 32'd4);
        for (int e = 3; e >= 0; e--) begin
            tick();
            rd_chk($sformatf("tval_cnt%0d", e), 14'h42, 32'(e));
        end
        tick();
        bit_chk("tflag_set", 14'h05, 11, 1'b1);
        rd_chk("tval_reload", 14'h42, 32'd4);
        wr(14'h44, 32'h1);
        bit_chk("tflag_clr", 14'h05, 11, 1'b0);
        repeat (3) tick();
        bit_chk("tflag_still_clr", 14'h05, 11, 1'b0);
        tick();
        bit_chk("tflag_period", 14'h05, 11, 1'b1);
        wr(14'h44, 32'h1);
        for (int g = 0; g < 20 && m_tval != 0; g++) tick();
        wr(14'h44, 32'h1);
        bit_chk("set_beats_clr", 14'h05, 11, 1'b1);

        wr(14'h41, 32'h0);
        wr(14'h44, 32'h1);
        bit_chk("tflag_off", 14'h05, 11, 1'b0);
        wr(14'h41, 32'h5);
        repeat (5) tick();
        bit_chk("oneshot_set", 14'h05, 11, 1'b1);
        rd_chk("oneshot_tval", 14'h42, TMASK);
        wr(14'h44, 32'h1);
        repeat (20) tick();
        bit_chk("oneshot_noflag", 14'h05, 11, 1'b0);
        rd_chk("oneshot_hold", 14'h42, TMASK);
        wr(14'h41, 32'h0);

        wr(14'h04, 32'h4);
        hw_int = 5'b00001;
        tick();
        bit_chk("hwi_is2", 14'h05, 2, 1'b1);
        chk("has_int_on", 32'(has_int), 32'h1);
        wr(14'h00, 32'h8);
        chk("has_int_ie0", 32'(has_int), 32'h0);

        bus.wb_ex = 1; bus.wb_pc = 32'h1c00_0200; bus.wb_badv_we = 1; bus.wb_vaddr = 32'h3;
        bus.csr_we = 1; bus.csr_num = 14'h06; bus.csr_wmask = 32'hffff_ffff; bus.csr_wvalue = 32'hdead_beef;
        tick();
        rd_chk("ex_beats_wr", 14'h06, 32'h1c00_0200);
        rd_chk("badv_we", 14'h07, 32'h3);
        bus.wb_ex = 1; bus.wb_badv_we = 0; bus.wb_vaddr = 32'h55;
        tick();
        rd_chk("badv_hold", 14'h07, 32'h3);

        for (int c = 0; c < 600; c++) begin
            bus.csr_we     = $urandom_range(0, 1);
            bus.csr_num    = addrs[$urandom_range(0, 18)];
            bus.csr_wmask  = ($urandom_range(0, 3) == 0) ? $urandom : 32'hffff_ffff;
            bus.csr_wvalue = $urandom;
            if (bus.csr_num == 14'h41 && $urandom_range(0, 1)) bus.csr_wvalue = $urandom_range(0, 31);
            bus.wb_ex       = ($urandom_range(0, 15) == 0);
            bus.wb_ertn     = ($urandom_range(0, 15) == 0);
            bus.wb_ecode    = 6'($urandom);
            bus.wb_esubcode = 9'($urandom);
            bus.wb_pc       = $urandom;
            bus.wb_badv_we  = $urandom_range(0, 1);
            bus.wb_vaddr    = $urandom;
            hw_int          = HWI'($urandom);
            ipi             = $urandom_range(0, 1);
            tick();
            chk("rnd_has_int", 32'(has_int),
                32'(m_crmd[2] && ((m_ecfg & m_estat & 32'h1fff) != 0)));
            chk("rnd_ex_entry", ex_entry, m_eentry);
            chk("rnd_ertn_entry", ertn_entry, m_era);
            mdl_chk(14'h42);
            mdl_chk(14'h05);
            mdl_chk(addrs[$urandom_range(0, 18)]);
            mdl_chk(addrs[$urandom_range(0, 18)]);
        end

        wr(14'h41, 32'h0000_fff1);
        repeat (3) tick();
        mdl_chk(14'h42);
        #20 resetn = 0;
        #1;
        m_reset();
        rd_chk("midrst_tval", 14'h42, 32'h0);
        rd_chk("midrst_tcfg", 14'h41, 32'h0);
        rd_chk("midrst_crmd", 14'h00, 32'h8);
        rd_chk("midrst_estat", 14'h05, 32'h0);
        @(posedge clk);
        #1 resetn = 1;
        tick();
        rd_chk("postrst_tval", 14'h42, 32'h0);
        mdl_chk(14'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
